// File: rtl/cgra_col_mem_arbiter.sv
// Per-column memory-port arbiter: muxes cell load/stores onto one port and routes read data
// back through an in-order ID FIFO. Define CGRA_ARB_ROUND_ROBIN_EN for round-robin selection.
module cgra_col_mem_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DP_WIDTH  = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               pc_en_i,
  input  logic [N_REQ-1:0]                   req_i,
  input  logic [N_REQ-1:0]                   wen_i,
  input  logic [N_REQ-1:0]                   ind_i,
  input  logic [N_REQ-1:0][DP_WIDTH-1:0]     add_i,
  input  logic [N_REQ-1:0][DP_WIDTH-1:0]     wdata_i,
  output logic                               data_req_o,
  output logic                               data_wen_o,
  output logic                               data_ind_o,
  output logic [DP_WIDTH-1:0]                data_add_o,
  output logic [DP_WIDTH-1:0]                data_wdata_o,
  input  logic                               data_gnt_i,
  input  logic                               data_rvalid_i,
  input  logic [DP_WIDTH-1:0]                data_rdata_i,
  output logic [N_REQ-1:0]                   gnt_o,
  output logic [N_REQ-1:0]                   rvalid_o,
  output logic [N_REQ-1:0][DP_WIDTH-1:0]     rdata_q_o,
  output logic [N_REQ-1:0]                   done_o,
  output logic                               stall_o,
  output logic                               spurious_o
);

  localparam int unsigned IdW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

  logic [N_REQ-1:0]               gs_q, gs_d, done_q, done_d, act;
  logic [IdW-1:0]                 win, head;
  logic                           any_act, fifo_full, fifo_empty, grant, push, pop;
  logic [IdW-1:0]                 fifo_q [MAX_OUTST];
  logic [PtrW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]                cnt_q;
  logic [N_REQ-1:0][DP_WIDTH-1:0] rdata_q;
  logic                           spurious_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign act = req_i & ~gs_q;

`ifdef CGRA_ARB_ROUND_ROBIN_EN
  logic [IdW-1:0] rr_ptr_q;

  // Scan downward so the last hit is the first active cell at or after rr_ptr_q.
  always_comb begin
    int unsigned    s;
    logic [IdW-1:0] idx;
    win     = '0;
    any_act = 1'b0;
    s       = 0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      s = 32'(rr_ptr_q) + 32'(k);
      if (s >= N_REQ) s = s - N_REQ;
      idx = IdW'(s);
      if (act[idx]) begin
        win     = idx;
        any_act = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (grant) begin
      rr_ptr_q <= (win == IdW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end
`else
  always_comb begin
    win     = '0;
    any_act = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (act[k]) begin
        win     = IdW'(k);
        any_act = 1'b1;
      end
    end
  end
`endif

  assign fifo_full  = (cnt_q == CntW'(MAX_OUTST));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Reads are held back while the ID FIFO is full; writes may still go out.
  assign data_req_o   = rst_ni & any_act & ~(fifo_full & wen_i[win]);
  assign data_wen_o   = any_act & wen_i[win];
  assign data_ind_o   = any_act & ind_i[win];
  assign data_add_o   = any_act ? add_i[win] : '0;
  assign data_wdata_o = (any_act & ~wen_i[win]) ? wdata_i[win] : '0;

  assign grant    = data_req_o & data_gnt_i;
  assign push     = grant & wen_i[win];
  assign pop      = rst_ni & data_rvalid_i & ~fifo_empty;
  assign gnt_o    = grant ? (N_REQ'(1) << win) : '0;
  assign rvalid_o = pop ? (N_REQ'(1) << head) : '0;

  always_comb begin
    gs_d   = gs_q | gnt_o;
    done_d = done_q | (gnt_o & ~wen_i) | rvalid_o;
    if (pc_en_i) begin
      gs_d   = '0;
      done_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gs_q       <= '0;
      done_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      gs_q   <= gs_d;
      done_q <= done_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q      <= ptr_inc(rd_ptr_q);
        rdata_q[head] <= data_rdata_i;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (data_rvalid_i && fifo_empty) spurious_q <= 1'b1;
    end
  end

  // ID storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= win;
  end

  assign rdata_q_o  = rdata_q;
  assign done_o     = done_q;
  assign stall_o    = |(req_i & ~done_q);
  assign spurious_o = spurious_q;

endmodule

// File: tb/tb_cgra_col_mem_arbiter.sv
// Directed bench for cgra_col_mem_arbiter: a combinational vector table after reset, then
// hand-written sequences for pipelined reads, back-pressure, mixed traffic, epochs and reset.
module tb_cgra_col_mem_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             pc_en_i;
  logic [3:0]       req_i, wen_i, ind_i;
  logic [3:0][31:0] add_i, wdata_i;
  logic             data_req_o, data_wen_o, data_ind_o;
  logic [31:0]      data_add_o, data_wdata_o;
  logic             data_gnt_i, data_rvalid_i;
  logic [31:0]      data_rdata_i;
  logic [3:0]       gnt_o, rvalid_o, done_o;
  logic [3:0][31:0] rdata_q_o;
  logic             stall_o, spurious_o;

  int n_tests = 0;
  int n_fail  = 0;

  cgra_col_mem_arbiter #(.N_REQ(4), .DP_WIDTH(32), .MAX_OUTST(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pc_en_i      (pc_en_i),
    .req_i        (req_i),
    .wen_i        (wen_i),
    .ind_i        (ind_i),
    .add_i        (add_i),
    .wdata_i      (wdata_i),
    .data_req_o   (data_req_o),
    .data_wen_o   (data_wen_o),
    .data_ind_o   (data_ind_o),
    .data_add_o   (data_add_o),
    .data_wdata_o (data_wdata_o),
    .data_gnt_i   (data_gnt_i),
    .data_rvalid_i(data_rvalid_i),
    .data_rdata_i (data_rdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_q_o    (rdata_q_o),
    .done_o       (done_o),
    .stall_o      (stall_o),
    .spurious_o   (spurious_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wen;
    logic        exp_req;
    logic        exp_wen;
    logic        exp_ind;
    logic [31:0] exp_add;
    logic [31:0] exp_wdata;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    pc_en_i       = 1'b0;
    req_i         = '0;
    wen_i         = '0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      add_i[k]   = 32'h100 + 32'(k) * 32'h10;
      wdata_i[k] = 32'h50 + 32'(k);
    end
    ind_i = 4'b0100;

    //         req      wen      req   wen   ind   add       wdata     stall
    vecs[0] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h000, 32'h00, 1'b0};
    vecs[1] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h50, 1'b1};
    vecs[2] = '{4'b0110, 4'b0010, 1'b1, 1'b1, 1'b0, 32'h110, 32'h00, 1'b1};
    vecs[3] = '{4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0, 32'h130, 32'h00, 1'b1};
    vecs[4] = '{4'b1100, 4'b0100, 1'b1, 1'b1, 1'b1, 32'h120, 32'h00, 1'b1};
    vecs[5] = '{4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0, 32'h100, 32'h50, 1'b1};

    do_reset();
    chk("reset_done", done_o, 4'b0000);
    chk("reset_spurious", spurious_o, 0);
    chk("reset_rdata0", rdata_q_o[0], 0);

    // Winner selection and muxing with grants withheld, so state never moves.
    for (int i = 0; i < 6; i++) begin
      req_i = vecs[i].req;
      wen_i = vecs[i].wen;
      #2;
      chk($sformatf("vec%0d_req", i), data_req_o, vecs[i].exp_req);
      chk($sformatf("vec%0d_wen", i), data_wen_o, vecs[i].exp_wen);
      chk($sformatf("vec%0d_ind", i), data_ind_o, vecs[i].exp_ind);
      chk($sformatf("vec%0d_add", i), data_add_o, vecs[i].exp_add);
      chk($sformatf("vec%0d_wdata", i), data_wdata_o, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_stall", i), stall_o, vecs[i].exp_stall);
      chk($sformatf("vec%0d_gnt", i), gnt_o, 4'b0000);
    end

    // Four pipelined reads, rvalid one cycle after each grant.
    do_reset();
    req_i = 4'b1111; wen_i = 4'b1111; data_gnt_i = 1'b1;
    #1 chk("rd4_gnt0", gnt_o, 4'b0001);
    for (int k = 1; k <= 4; k++) begin
      step();
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'hA0 + 32'(k - 1);
      #1;
      chk($sformatf("rd4_gnt%0d", k), gnt_o, (k < 4) ? (4'b0001 << k) : 4'b0000);
      chk($sformatf("rd4_rvalid%0d", k), rvalid_o, 4'b0001 << (k - 1));
      chk($sformatf("rd4_stall%0d", k), stall_o, 1);
    end
    step();
    data_rvalid_i = 1'b0;
    #1;
    chk("rd4_stall_end", stall_o, 0);
    chk("rd4_done", done_o, 4'b1111);
    for (int k = 0; k < 4; k++) chk($sformatf("rd4_rdata%0d", k), rdata_q_o[k], 32'hA0 + 32'(k));

    // Outstanding limit: third read waits for the first response.
    do_reset();
    req_i = 4'b0111; wen_i = 4'b0111; data_gnt_i = 1'b1;
    #1 chk("outst_gnt0", gnt_o, 4'b0001);
    step();
    chk("outst_gnt1", gnt_o, 4'b0010);
    for (int c = 2; c < 5; c++) begin
      step();
      chk($sformatf("outst_blocked%0d", c), data_req_o, 0);
    end
    step();
    data_rvalid_i = 1'b1; data_rdata_i = 32'h11;
    #1;
    chk("outst_rvalid", rvalid_o, 4'b0001);
    chk("outst_req_at_rvalid", data_req_o, 0);
    step();
    data_rvalid_i = 1'b0;
    #1;
    chk("outst_gnt2", gnt_o, 4'b0100);
    chk("outst_rdata0", rdata_q_o[0], 32'h11);

    // Mixed write then read.
    do_reset();
    wdata_i[0] = 32'h55;
    req_i = 4'b0011; wen_i = 4'b0010; data_gnt_i = 1'b1;
    #1;
    chk("mix_gnt0", gnt_o, 4'b0001);
    chk("mix_wen", data_wen_o, 0);
    chk("mix_wdata", data_wdata_o, 32'h55);
    chk("mix_add", data_add_o, 32'h100);
    step();
    chk("mix_done0", done_o, 4'b0001);
    chk("mix_gnt1", gnt_o, 4'b0010);
    step();
    data_rvalid_i = 1'b1; data_rdata_i = 32'hBEEF;
    #1 chk("mix_rvalid", rvalid_o, 4'b0010);
    step();
    data_rvalid_i = 1'b0;
    #1;
    chk("mix_rdata1", rdata_q_o[1], 32'hBEEF);
    chk("mix_rdata0", rdata_q_o[0], 0);
    chk("mix_done", done_o, 4'b0011);

    // Spurious response with empty FIFO.
    do_reset();
    data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD;
    #1 chk("spur_rvalid", rvalid_o, 4'b0000);
    step();
    data_rvalid_i = 1'b0;
    step();
    step();
    chk("spur_sticky", spurious_o, 1);
    chk("spur_rdata0", rdata_q_o[0], 0);
    do_reset();
    chk("spur_cleared", spurious_o, 0);

    // Epoch order: cell 2 granted last, then a new epoch with all cells requesting.
    req_i = 4'b0111; wen_i = 4'b0000; data_gnt_i = 1'b1;
    #1 chk("ep1_gnt0", gnt_o, 4'b0001);
    step(); chk("ep1_gnt1", gnt_o, 4'b0010);
    step(); chk("ep1_gnt2", gnt_o, 4'b0100);
    step();
    req_i = 4'b0000; pc_en_i = 1'b1;
    step();
    pc_en_i = 1'b0; req_i = 4'b1111;
    #1;
`ifdef CGRA_ARB_ROUND_ROBIN_EN
    chk("ep2_first_gnt", gnt_o, 4'b1000);
`else
    chk("ep2_first_gnt", gnt_o, 4'b0001);
`endif

    // pc_en coincident with a response: data lands, done is cleared.
    do_reset();
    req_i = 4'b0001; wen_i = 4'b0001; data_gnt_i = 1'b1;
    #1 chk("pcen_gnt", gnt_o, 4'b0001);
    step();
    data_rvalid_i = 1'b1; data_rdata_i = 32'h77; pc_en_i = 1'b1;
    #1 chk("pcen_rvalid", rvalid_o, 4'b0001);
    step();
    data_rvalid_i = 1'b0; pc_en_i = 1'b0; req_i = 4'b0000;
    #1;
    chk("pcen_rdata0", rdata_q_o[0], 32'h77);
    chk("pcen_done", done_o, 4'b0000);

    // Reset in the middle of an outstanding read.
    req_i = 4'b0001;
    #1 chk("rstmid_gnt", gnt_o, 4'b0001);
    step();
    data_rvalid_i = 1'b1; data_rdata_i = 32'h99; rst_ni = 1'b0;
    #1;
    chk("rstmid_req", data_req_o, 0);
    chk("rstmid_gnto", gnt_o, 0);
    chk("rstmid_rvalid", rvalid_o, 0);
    chk("rstmid_done", done_o, 0);
    chk("rstmid_rdata0", rdata_q_o[0], 0);
    chk("rstmid_spur", spurious_o, 0);
    step();
    rst_ni = 1'b1; req_i = 4'b0000;
    #1 chk("rstmid_fifo_empty", rvalid_o, 4'b0000);
    step();
    data_rvalid_i = 1'b0;
    chk("rstmid_spur_after", spurious_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
